data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-through, no-write-allocate data cache for the memory stage of the pipelined MIPS data path. It sits between the M pipeline register (ALUOutM/WriteDataM/MemWriteM/MemToRegM) and a slow word-wide backing memory. It raises `memstall` to freeze the pipeline while a miss refill or a write-through is in progress. The block is synchronous to one clock and has a 4-word line refill engine and a write-through port.

## Interface
- `LINES`, 16: number of cache lines, a power of two. Index width is IW = log2(LINES).
- `WORDS`, 4: words per line, fixed at 4. Offset is `addr[3:2]`.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low (asserted at 0).
- `MemWrite`  in  1: store request (from MemWriteM).
- `MemRead`  in  1: load request (from MemToRegM).
- `addr`  in  32: byte address, word-aligned; `addr[1:0]` is ignored.
- `wdata`  in  32: store data.
- `rdata`  out  32: load data.
- `memstall`  out  1: pipeline freeze request.
- `mem_req`  out  1: backing-memory request.
- `mem_we`  out  1: backing-memory write enable.
- `mem_addr`  out  32: backing-memory word address, low 2 bits always 0.
- `mem_wdata`  out  32: backing-memory write data.
- `mem_rdata`  in  32: backing-memory read data, valid on the `mem_ack` cycle.
- `mem_ack`  in  1: one-cycle completion pulse for the current request.

## Operation
- Address split: offset `addr[3:2]`, index `addr[3+IW:4]`, tag `addr[31:4+IW]`.
- Storage per line: 1 valid bit, 1 tag, 4 data words.
  - Reset clears only the valid bits.
  - The data and tag arrays are not reset.
- Hit condition: valid[index] & tag match.
- The pipeline holds `addr`, `wdata`, `MemWrite` and `MemRead` stable while `memstall`=1. The block does not latch them.
- If `MemWrite` and `MemRead` are both 1, `MemWrite` wins and the access is treated as a store.
- FSM states: IDLE, REFILL, WRITE, DONE.
- IDLE
  - Read hit: `memstall`=0 and `rdata` = the hit word, combinationally in the same cycle. State stays IDLE.
  - Read miss: `memstall`=1 combinationally. Next state REFILL, word counter cnt=0.
  - Write (hit or miss): `memstall`=1 combinationally. Next state WRITE.
  - No request: `memstall`=0.
- REFILL
  - Outputs: `memstall`=1, `mem_req`=1, `mem_we`=0, `mem_addr` = {addr[31:4], cnt, 2'b00}.
  - On `mem_ack`: write `mem_rdata` into line word cnt, then cnt increments.
  - On the ack with cnt=3: set valid and tag for the line, next state IDLE. The retried read then hits.
  - `mem_req` stays high across consecutive words; only `mem_addr` advances.
- WRITE
  - Outputs: `memstall`=1, `mem_req`=1, `mem_we`=1, `mem_addr` = {addr[31:2], 2'b00}, `mem_wdata` = `wdata`.
  - On `mem_ack`: if the access hits, update the cached word (the valid bit is unchanged). A write miss does not allocate. Next state DONE.
- DONE
  - Exactly one cycle with `memstall`=0, so the store retires.
  - Request inputs are ignored in this cycle. Next state IDLE.
- `rdata` is 0 in every cycle that is not an IDLE read hit.
- In IDLE and DONE: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.

## Timing
- Reset values while `reset`=0:
  - State IDLE, cnt=0, all valid bits 0.
  - `memstall`=0, `rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset assertion takes effect asynchronously, including in the middle of a REFILL or WRITE.
  - A partially refilled line is left invalid.
  - `mem_req` drops immediately.
- Read-hit latency: 0 cycles, no stall.
- Read-miss stall: 1 + (sum of the four request-to-ack latencies) cycles, followed by the hit cycle.
- Write stall: 1 + (request-to-ack latency) cycles, followed by the DONE retire cycle.
- Handshake:
  - `mem_ack` is only meaningful while `mem_req`=1. An ack with `mem_req`=0 is ignored.
  - The backing memory must not ack in the same cycle that `mem_req` first rises.

## Test plan
- Cold read, bench memory acks in the 2nd cycle of each request, mem[0x100..0x10C] = 0xA0..0xA3:
  - Read 0x104 -> `memstall`=1 for 9 cycles.
  - `mem_addr` sequence is 0x100, 0x104, 0x108, 0x10C.
  - 10th cycle: `memstall`=0, `rdata`=0xA1.
  - Then read 0x10C -> no stall, `rdata`=0xA3.
- Write hit, after the refill above:
  - Write 0x108 with 0xDEADBEEF -> `mem_we`=1, `mem_addr`=0x108, `memstall` high for 3 cycles, then 1 DONE cycle.
  - Then read 0x108 -> no stall, `rdata`=0xDEADBEEF.
- Write miss to 0x200 with 0x55:
  - Backing memory is written.
  - A subsequent read of 0x200 misses and refills, i.e. no allocation on the write.
- Conflict, with LINES=16:
  - Read 0x100, then read 0x200 (same index 0, different tag), then read 0x100 again.
  - All three miss; each refill has a 9-cycle stall.
- Reset mid-refill:
  - Assert `reset`=0 after the 2nd ack of a miss to 0x300.
  - All outputs go to 0 immediately.
  - After release, read 0x300 misses and restarts from word 0 (`mem_addr`=0x300).
- `MemWrite`=`MemRead`=1 at 0x104 -> treated as a store: `mem_we`=1, and `rdata` stays 0.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MIPS memory stage.
// Stalls the pipeline during 4-word line refills and single-word write-throughs.
module data_cache #(
   parameter int unsigned LINES = 16,
   parameter int unsigned WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        memstall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int unsigned IW = $clog2(LINES);
   localparam int unsigned TW = 28 - IW;
   localparam logic [1:0]  LAST_WORD = 2'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      REFILL,
      WRITE,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [LINES-1:0]   valid_q, valid_d;

   logic [TW-1:0]      tag_mem  [LINES];
   logic [31:0]        data_mem [LINES][WORDS];

   logic [IW-1:0]      idx;
   logic [TW-1:0]      tag;
   logic [1:0]         off;
   logic               hit;

   logic               data_we;
   logic [1:0]         data_word;
   logic [31:0]        data_wval;
   logic               tag_we;

   logic [1:0]         unused_addr_lsbs;

   assign idx = addr[3+IW:4];
   assign tag = addr[31:4+IW];
   assign off = addr[3:2];
   assign hit = valid_q[idx] && (tag_mem[idx] == tag);
   assign unused_addr_lsbs = addr[1:0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      data_we   = 1'b0;
      data_word = '0;
      data_wval = '0;
      tag_we    = 1'b0;
      rdata     = '0;
      memstall  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      // Outputs are forced quiet while reset is held, even with a request pending.
      if (reset) begin
         unique case (state_q)
            IDLE: begin
               if (MemWrite) begin
                  memstall = 1'b1;
                  state_d  = WRITE;
               end else if (MemRead) begin
                  if (hit) begin
                     rdata = data_mem[idx][off];
                  end else begin
                     // Invalidate up front so an aborted refill never leaves a stale-tagged line.
                     memstall     = 1'b1;
                     state_d      = REFILL;
                     cnt_d        = '0;
                     valid_d[idx] = 1'b0;
                  end
               end
            end

            REFILL: begin
               memstall = 1'b1;
               mem_req  = 1'b1;
               mem_addr = {addr[31:4], cnt_q, 2'b00};
               if (mem_ack) begin
                  data_we   = 1'b1;
                  data_word = cnt_q;
                  data_wval = mem_rdata;
                  cnt_d     = cnt_q + 2'd1;
                  if (cnt_q == LAST_WORD) begin
                     tag_we       = 1'b1;
                     valid_d[idx] = 1'b1;
                     cnt_d        = '0;
                     state_d      = IDLE;
                  end
               end
            end

            WRITE: begin
               memstall  = 1'b1;
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = {addr[31:2], 2'b00};
               mem_wdata = wdata;
               if (mem_ack) begin
                  if (hit) begin
                     data_we   = 1'b1;
                     data_word = off;
                     data_wval = wdata;
                  end
                  state_d = DONE;
               end
            end

            DONE: begin
               state_d = IDLE;
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   // Tag and data arrays carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (data_we) begin
         data_mem[idx][data_word] <= data_wval;
      end
      if (tag_we) begin
         tag_mem[idx] <= tag;
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios then randomized accesses,
// checked against a line-level cache model and an associative backing memory.
module tb_data_cache;

   localparam int unsigned LINES = 16;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        memstall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int checks = 0;
   int errors = 0;

   // Backing memory (word address -> data) and cache model.
   logic [31:0] bmem [logic [31:0]];
   bit          mvalid [LINES];
   int unsigned mtag   [LINES];
   logic [31:0] mdata  [LINES][4];

   data_cache #(.LINES(LINES), .WORDS(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .memstall  (memstall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd_mem(input logic [31:0] wa);
      if (bmem.exists(wa)) return bmem[wa];
      return wa ^ 32'hC0DE_0000;
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_memstall"}, {31'd0, memstall}, 32'd0);
      chk({tag, "_rdata"}, rdata, 32'd0);
      chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      #1;
      chk_quiet("idle");
   endtask

   // One pipeline access, acting as the backing memory. Each request is acked in
   // cycle `lat` of that request (lat >= 2). abort_acks>0 asserts reset after that many acks.
   task automatic access(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d,
                         input int lat_lo, input int lat_hi, input int abort_acks);
      logic [31:0] wa;
      logic [31:0] base;
      int unsigned idx, tg, off;
      bit store, hit;
      int stall, exp_stall, reqc, lat, acks, guard, exp_acks;
      wa    = {a[31:2], 2'b00};
      base  = {a[31:4], 4'h0};
      idx   = (a / 16) % LINES;
      tg    = a / (16 * LINES);
      off   = (a / 4) % 4;
      store = we;
      hit   = mvalid[idx] && (mtag[idx] == tg);
      exp_acks  = store ? 1 : (hit ? 0 : 4);
      exp_stall = (exp_acks == 0) ? 0 : 1;
      stall = 0; reqc = 0; acks = 0; guard = 0;
      lat = $urandom_range(lat_hi, lat_lo);

      @(negedge clk);
      MemWrite = we;
      MemRead  = re;
      addr     = a;
      wdata    = d;
      mem_ack  = 1'b0;
      #1;
      while (memstall === 1'b1 && guard < 200) begin
         guard++;
         stall++;
         chk("rdata_during_stall", rdata, 32'd0);
         if (mem_req === 1'b1) begin
            reqc++;
            if (reqc == 1) exp_stall += lat;
            chk("mem_we", {31'd0, mem_we}, {31'd0, store});
            chk("mem_addr", mem_addr, store ? wa : base + 32'(4 * acks));
            if (store) chk("mem_wdata", mem_wdata, d);
            if (reqc == lat) begin
               mem_ack = 1'b1;
               if (store) bmem[mem_addr] = mem_wdata;
               else mem_rdata = rd_mem(base + 32'(4 * acks));
            end
         end
         @(negedge clk);
         if (mem_ack) begin
            acks++;
            reqc = 0;
            lat  = $urandom_range(lat_hi, lat_lo);
         end
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (abort_acks != 0 && acks == abort_acks) begin
            reset = 1'b0;
            #1;
            chk_quiet("async_reset");
            for (int unsigned i = 0; i < LINES; i++) mvalid[i] = 1'b0;
            @(negedge clk);
            #1;
            chk_quiet("held_reset");
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            return;
         end
         #1;
      end

      chk("memstall_end", {31'd0, memstall}, 32'd0);
      chk("mem_req_end", {31'd0, mem_req}, 32'd0);
      chk("stall_cycles", stall, exp_stall);
      chk("request_count", acks, exp_acks);
      if (store) begin
         chk("rdata_done", rdata, 32'd0);
         chk("bmem_written", rd_mem(wa), d);
         if (hit) mdata[idx][off] = d;
      end else begin
         if (!hit) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            for (int w = 0; w < 4; w++) mdata[idx][w] = rd_mem(base + 32'(4 * w));
         end
         chk("rdata", rdata, mdata[idx][off]);
      end
   endtask

   initial begin
      logic [31:0] a, d;
      int unsigned op;
      reset     = 1'b0;
      MemWrite  = 1'b0;
      MemRead   = 1'b1;
      addr      = 32'h104;
      wdata     = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      for (int unsigned i = 0; i < LINES; i++) mvalid[i] = 1'b0;
      for (int i = 0; i < 4; i++) bmem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);

      repeat (2) @(negedge clk);
      #1;
      chk_quiet("reset");
      @(negedge clk);
      MemRead = 1'b0;
      reset   = 1'b1;
      idle_cycle();

      // Cold read: 9 stall cycles, then A1; neighbour word hits.
      access(1'b0, 1'b1, 32'h104, 32'd0, 2, 2, 0);
      chk("cold_read_value", rdata, 32'hA1);
      access(1'b0, 1'b1, 32'h10C, 32'd0, 2, 2, 0);
      chk("hit_read_value", rdata, 32'hA3);

      // Write hit, then read back.
      access(1'b1, 1'b0, 32'h108, 32'hDEADBEEF, 2, 2, 0);
      access(1'b0, 1'b1, 32'h108, 32'd0, 2, 2, 0);
      chk("write_hit_readback", rdata, 32'hDEADBEEF);

      // Write miss does not allocate; following read refills.
      access(1'b1, 1'b0, 32'h200, 32'h55, 2, 2, 0);
      access(1'b0, 1'b1, 32'h200, 32'd0, 2, 2, 0);
      chk("write_miss_readback", rdata, 32'h55);

      // Conflict on index 0.
      access(1'b0, 1'b1, 32'h100, 32'd0, 2, 2, 0);
      access(1'b0, 1'b1, 32'h200, 32'd0, 2, 2, 0);
      access(1'b0, 1'b1, 32'h100, 32'd0, 2, 2, 0);
      chk("conflict_value", rdata, 32'hA0);

      // Reset in the middle of a refill, then a clean restart.
      access(1'b0, 1'b1, 32'h300, 32'd0, 2, 2, 2);
      access(1'b0, 1'b1, 32'h300, 32'd0, 2, 2, 0);
      access(1'b0, 1'b1, 32'h100, 32'd0, 2, 2, 0);

      // Both strobes: treated as a store.
      access(1'b1, 1'b1, 32'h104, 32'h1234_5678, 2, 2, 0);
      access(1'b0, 1'b1, 32'h104, 32'd0, 2, 2, 0);
      chk("both_strobes_readback", rdata, 32'h1234_5678);
      idle_cycle();

      // Randomized accesses over 4 tags x 16 lines, variable ack latency.
      for (int n = 0; n < 80; n++) begin
         a  = (32'($urandom_range(3, 0)) << 8) | (32'($urandom_range(15, 0)) << 4) |
              (32'($urandom_range(3, 0)) << 2) | 32'($urandom_range(3, 0));
         d  = $urandom;
         op = $urandom_range(9, 0);
         if (op < 5)      access(1'b0, 1'b1, a, d, 2, 4, 0);
         else if (op < 8) access(1'b1, 1'b0, a, d, 2, 4, 0);
         else if (op < 9) access(1'b1, 1'b1, a, d, 2, 4, 0);
         else             idle_cycle();
      end
      idle_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
